// File: rtl/rx_pkg.sv
// ============================================================================
// Module : rx_pkg
// Brief  : Shared receiver state encoding and line-level constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam logic RX_IDLE_LEVEL = 1'b1;
  localparam logic RX_STOP_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rx_deserializer.sv
// ============================================================================
// Module : rx_deserializer
// Brief  : 8N1-style line synchronizer, framing FSM and LSB-first shifter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_deserializer
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx,
  output logic                  o_byte_stb,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_stop_ok
);

  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int c_BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [c_BAUD_W-1:0] c_HALF_M1 = c_BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_BAUD_W-1:0] c_BIT_M1  = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0]  c_LAST    = c_BIT_W'(DATA_WIDTH - 1);

  logic                  r_sync1, r_sync2;
  rx_state_t             r_state, w_state_nxt;
  logic [c_BAUD_W-1:0]   r_baud, w_baud_nxt;
  logic [c_BIT_W-1:0]    r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_stb, w_stb_nxt;
  logic                  r_stop_ok, w_stop_ok_nxt;
  logic                  w_rx_s;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= RX_IDLE_LEVEL;
      r_sync2   <= RX_IDLE_LEVEL;
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_stb     <= 1'b0;
      r_stop_ok <= 1'b0;
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_stb     <= w_stb_nxt;
      r_stop_ok <= w_stop_ok_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud + c_BAUD_W'(1);
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_stb_nxt     = 1'b0;
    w_stop_ok_nxt = r_stop_ok;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (w_rx_s != RX_IDLE_LEVEL) w_state_nxt = START;
      end
      START: begin
        // Mid-bit recheck of the start bit filters short line glitches.
        if (r_baud == c_HALF_M1) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = (w_rx_s == RX_IDLE_LEVEL) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_baud == c_BIT_M1) begin
          w_baud_nxt              = '0;
          w_shift_nxt             = r_shift >> 1;
          w_shift_nxt[DATA_WIDTH-1] = w_rx_s;
          if (r_bit == c_LAST) w_state_nxt = STOP;
          else                 w_bit_nxt   = r_bit + c_BIT_W'(1);
        end
      end
      STOP: begin
        if (r_baud == c_BIT_M1) begin
          w_baud_nxt    = '0;
          w_stb_nxt     = 1'b1;
          w_stop_ok_nxt = (w_rx_s == RX_STOP_LEVEL);
          w_state_nxt   = (w_rx_s == RX_STOP_LEVEL) ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start bit counts.
        w_baud_nxt = '0;
        if (w_rx_s == RX_IDLE_LEVEL) w_state_nxt = IDLE;
      end
      default: begin
        w_baud_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_byte_stb = r_stb;
  assign o_data     = r_shift;
  assign o_stop_ok  = r_stop_ok;

endmodule

`default_nettype wire

// File: rtl/rx_ram_capture.sv
// ============================================================================
// Module : rx_ram_capture
// Brief  : Serial receiver storing good bytes into a small RAM with read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_ram_capture
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  clear,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  byte_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = (ADDR_WIDTH + 1)'(c_DEPTH);

  logic                  w_byte_stb;
  logic [DATA_WIDTH-1:0] w_byte_data;
  logic                  w_stop_ok;
  logic                  w_write;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_q;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_byte_valid, r_frame_err, r_overrun;

  rx_deserializer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (rx),
    .o_byte_stb (w_byte_stb),
    .o_data     (w_byte_data),
    .o_stop_ok  (w_stop_ok)
  );

  assign full    = (r_count == c_FULL_COUNT);
  // clear takes priority over a byte landing in the same cycle.
  assign w_write = w_byte_stb & w_stop_ok & ~full & ~clear & ~rst;

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= w_byte_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q          <= '0;
      r_byte_valid <= 1'b0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_byte_valid <= w_write;
      if (clear) begin
        r_wr_ptr    <= '0;
        r_count     <= '0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end else begin
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
          r_count  <= r_count + (ADDR_WIDTH + 1)'(1);
        end
        if (w_byte_stb && w_stop_ok && full) r_overrun   <= 1'b1;
        if (w_byte_stb && !w_stop_ok)        r_frame_err <= 1'b1;
      end
      if (read) r_q <= r_mem[addr];
    end
  end

  assign q          = r_q;
  assign byte_valid = r_byte_valid;
  assign count      = r_count;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_rx_ram_capture.sv
// ============================================================================
// Module : tb_rx_ram_capture
// Brief  : Self-checking bench for rx_ram_capture (tables, corners, random).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_ram_capture;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = (DW + 2) * CPB;
  // Negedges from driving the start bit until byte_valid is seen:
  // 2 sync + 1 detect + CPB/2 + DW*CPB + CPB + 1 write.
  localparam int BV_LAT = 3 + CPB / 2 + DW * CPB + CPB + 1;

  logic clk = 1'b0;
  logic rst, rx, clear, read;
  logic [AW-1:0] addr;
  logic [DW-1:0] q;
  logic byte_valid, full, frame_err, overrun;
  logic [AW:0] count;

  always #5 clk = ~clk;

  rx_ram_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .clear(clear), .read(read), .addr(addr),
    .q(q), .byte_valid(byte_valid), .count(count), .full(full),
    .frame_err(frame_err), .overrun(overrun)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a bounded FIFO-like store with sticky flags.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            m_count, m_wptr;
  bit            m_ferr, m_ovr;

  task automatic m_clear();
    m_count = 0; m_wptr = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic m_frame(input logic [DW-1:0] d, input logic stopb, output bit stored);
    stored = 0;
    if (!stopb) m_ferr = 1;
    else if (m_count >= DEPTH) m_ovr = 1;
    else begin
      m_mem[m_wptr] = d; m_known[m_wptr] = 1;
      m_wptr = (m_wptr + 1) % DEPTH; m_count++; stored = 1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stopb, input int clr_at,
                            input int abort_at, output int bv_n, output int bv_at);
    bv_n = 0; bv_at = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == abort_at) break;
      clear = (k == clr_at);
      if (k < CPB)                 rx = 1'b0;
      else if (k < (DW + 1) * CPB) rx = d[(k - CPB) / CPB];
      else                         rx = stopb;
      @(negedge clk);
      if (byte_valid) begin
        bv_n++;
        if (bv_at == 0) bv_at = k + 1;
      end
    end
    clear = 1'b0;
  endtask

  task automatic line(input logic lvl, input int n, output int bvs);
    bvs = 0;
    rx = lvl;
    repeat (n) begin
      @(negedge clk);
      if (byte_valid) bvs++;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    m_clear();
  endtask

  task automatic read_addr(input logic [AW-1:0] a, output logic [DW-1:0] v);
    read = 1'b1; addr = a;
    @(negedge clk);
    read = 1'b0;
    v = q;
  endtask

  task automatic check_status(input string tag, input int c, input logic f,
                              input logic fe, input logic ov);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
    check({tag, ".overrun"}, 32'(overrun), 32'(ov));
  endtask

  task automatic check_model(input string tag);
    check_status(tag, m_count, m_count == DEPTH, m_ferr, m_ovr);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          stopb;
    logic          clr;
    int            cnt;
    logic          f;
    logic          fe;
    logic          ov;
  } vec_t;

  vec_t tbl [8];

  task automatic run_vec(input int i);
    int bvn, bvat, bvx;
    bit st;
    if (tbl[i].clr) pulse_clear();
    send_frame(tbl[i].d, tbl[i].stopb, -1, -1, bvn, bvat);
    m_frame(tbl[i].d, tbl[i].stopb, st);
    if (!tbl[i].stopb) begin
      line(1'b0, 40, bvx);
      bvn += bvx;
    end
    line(1'b1, 20, bvx);
    check($sformatf("vec%0d.byte_valid_pulses", i), 32'(bvn + bvx), 32'(tbl[i].stopb && tbl[i].cnt > 0 && !tbl[i].ov ? 1 : 0));
    check_status($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].f, tbl[i].fe, tbl[i].ov);
  endtask

  initial begin
    int bvn, bvat, bvx;
    bit st;
    logic [DW-1:0] v, d;
    logic [DW-1:0] exp_a [4];
    logic [AW-1:0] ra;
    logic sb;

    tbl[0] = '{8'h01, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h80, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h3C, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h55, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h22, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'h42, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h11, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0};
    exp_a[0] = 8'h01; exp_a[1] = 8'h80; exp_a[2] = 8'hFF; exp_a[3] = 8'h3C;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

    rst = 1'b1; rx = 1'b1; clear = 1'b0; read = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    check("reset.q", 32'(q), 32'h0);
    check("reset.byte_valid", 32'(byte_valid), 32'h0);
    check_status("reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    m_clear();
    line(1'b1, 10, bvx);

    // Single byte: latency, count and read-back
    send_frame(8'hA5, 1'b1, -1, -1, bvn, bvat);
    m_frame(8'hA5, 1'b1, st);
    check("a5.byte_valid_pulses", 32'(bvn), 32'd1);
    check("a5.byte_valid_latency", 32'(bvat), 32'(BV_LAT));
    line(1'b1, 20, bvx);
    check("a5.idle_pulses", 32'(bvx), 32'd0);
    check_status("a5", 1, 1'b0, 1'b0, 1'b0);
    read_addr(2'd0, v);
    check("a5.q", 32'(v), 32'hA5);
    addr = 2'd3;
    @(negedge clk);
    check("a5.q_hold", 32'(q), 32'hA5);

    // Fill to full, then overrun
    for (int i = 0; i < 5; i++) run_vec(i);
    for (int i = 0; i < DEPTH; i++) begin
      read_addr(AW'(i), v);
      check($sformatf("fill.q%0d", i), 32'(v), 32'(exp_a[i]));
    end

    // Clear while full, next byte goes to address 0
    pulse_clear();
    send_frame(8'h99, 1'b1, -1, -1, bvn, bvat);
    m_frame(8'h99, 1'b1, st);
    line(1'b1, 20, bvx);
    check_status("clr99", 1, 1'b0, 1'b0, 1'b0);
    read_addr(2'd0, v);
    check("clr99.q0", 32'(v), 32'h99);
    read_addr(2'd1, v);
    check("clr99.q1_old", 32'(v), 32'h80);

    // Framing error, break hold, recovery
    for (int i = 5; i < 8; i++) run_vec(i);
    read_addr(2'd0, v);
    check("ferr.q0", 32'(v), 32'h22);
    read_addr(2'd1, v);
    check("ferr.q1", 32'(v), 32'h11);

    // Short low glitch on an idle line
    pulse_clear();
    rx = 1'b0;
    repeat (6) @(negedge clk);
    line(1'b1, 30, bvx);
    check("glitch.pulses", 32'(bvx), 32'd0);
    check_status("glitch", 0, 1'b0, 1'b0, 1'b0);

    // clear on the very cycle the byte would be written
    send_frame(8'h33, 1'b1, -1, -1, bvn, bvat);
    m_frame(8'h33, 1'b1, st);
    line(1'b1, 20, bvx);
    send_frame(8'h5A, 1'b1, BV_LAT - 1, -1, bvn, bvat);
    m_clear();
    line(1'b1, 20, bvx);
    check("clrwr.pulses", 32'(bvn + bvx), 32'd0);
    check_status("clrwr", 0, 1'b0, 1'b0, 1'b0);
    read_addr(2'd1, v);
    check("clrwr.q1", 32'(v), 32'h11);

    // clear mid-frame leaves the frame intact
    send_frame(8'h6B, 1'b1, 40, -1, bvn, bvat);
    m_clear();
    m_frame(8'h6B, 1'b1, st);
    line(1'b1, 20, bvx);
    check("clrmid.pulses", 32'(bvn), 32'd1);
    check_status("clrmid", 1, 1'b0, 1'b0, 1'b0);
    read_addr(2'd0, v);
    check("clrmid.q0", 32'(v), 32'h6B);

    // Reset during the data bits
    send_frame(8'hC3, 1'b1, -1, 80, bvn, bvat);
    rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstmid.q", 32'(q), 32'h0);
    check("rstmid.byte_valid", 32'(byte_valid), 32'h0);
    check_status("rstmid", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    m_clear();
    line(1'b1, 10, bvx);
    send_frame(8'h7E, 1'b1, -1, -1, bvn, bvat);
    m_frame(8'h7E, 1'b1, st);
    line(1'b1, 20, bvx);
    check("rst7e.pulses", 32'(bvn + bvx), 32'd1);
    check_status("rst7e", 1, 1'b0, 1'b0, 1'b0);
    read_addr(2'd0, v);
    check("rst7e.q0", 32'(v), 32'h7E);

    // Random frames against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) pulse_clear();
      d  = DW'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      send_frame(d, sb, -1, -1, bvn, bvat);
      m_frame(d, sb, st);
      if (!sb) begin
        line(1'b0, int'($urandom_range(5, 40)), bvx);
        bvn += bvx;
      end
      line(1'b1, 20, bvx);
      check($sformatf("rnd%0d.pulses", n), 32'(bvn + bvx), 32'(st));
      check_model($sformatf("rnd%0d", n));
      ra = AW'($urandom_range(0, DEPTH - 1));
      read_addr(ra, v);
      if (m_known[ra]) check($sformatf("rnd%0d.q%0d", n, ra), 32'(v), 32'(m_mem[ra]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
